// File: rtl/contador_varredura_erro.sv
// -----------------------------------------------------------------------------
// contador_varredura_erro
//
// Scan controller for the money-validation error display. A request on
// erro_valor starts (or restarts) a message. The message is shown for
// HOLD_FRAMES complete 4-digit scan frames, and each digit stays lit for DIV
// clock cycles. The controller drives two outputs:
//   - the 2-bit digit select feeding the error decoder, and
//   - the four active-low anodes of the multiplexed 7-segment display.
//
// Parameters:
//   DIV          clock cycles per lit digit (>= 1)
//   HOLD_FRAMES  scan frames shown per request (1..65535)
//
// Ports:
//   clock           system clock, rising edge
//   reset_n         asynchronous active-low reset
//   erro_valor      error request (pulse or level), sampled every edge
//   saida1Contador  digit-select MSB to the decoder
//   saida2Contador  digit-select LSB to the decoder
//   anodo[3:0]      active-low digit enables, bit n low = digit n lit
//   ativo           high while the message is being displayed
//
// Optional feature: define ERDI_PISCA_EN to make the message blink. The
// anodes are blanked in frames where frame-counter bit 3 is set, giving
// 8 frames on and 8 frames off. The select outputs, ativo and the total
// duration are unchanged.
// -----------------------------------------------------------------------------
module contador_varredura_erro #(
  parameter int DIV         = 50000,
  parameter int HOLD_FRAMES = 250
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       erro_valor,
  output logic       saida1Contador,
  output logic       saida2Contador,
  output logic [3:0] anodo,
  output logic       ativo
);

  localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  localparam logic [15:0]     FRAME_LOAD = 16'(HOLD_FRAMES - 1);

`ifdef ERDI_PISCA_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef enum logic {IDLE, SHOW} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [1:0]    digit;
  logic [15:0]   frame_cnt;

  logic [1:0]    digit_inc;
  logic [15:0]   frame_dec;

  assign digit_inc = digit + 2'd1;
  assign frame_dec = frame_cnt - 16'd1;

  // Anode pattern for a digit. The frame-counter bit 3 blanks the display
  // only when blinking is enabled.
  function automatic logic [3:0] anode_for(input logic [1:0] d, input logic f3);
    if (BLINK && f3) return 4'b1111;
    return ~(4'b0001 << d);
  endfunction

  // The outputs are registered alongside the counters and are always loaded
  // with the values that match the next digit. As a result, the select and
  // anode change on the same edge.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      presc          <= '0;
      digit          <= '0;
      frame_cnt      <= '0;
      anodo          <= 4'b1111;
      saida1Contador <= 1'b0;
      saida2Contador <= 1'b0;
      ativo          <= 1'b0;
    end else if (erro_valor) begin
      // Entry and retrigger are identical. A retrigger also wins over a
      // frame end in the same cycle, so the block never drops to IDLE here.
      state          <= SHOW;
      presc          <= '0;
      digit          <= 2'd0;
      frame_cnt      <= FRAME_LOAD;
      anodo          <= anode_for(2'd0, FRAME_LOAD[3]);
      saida1Contador <= 1'b0;
      saida2Contador <= 1'b0;
      ativo          <= 1'b1;
    end else if (state == SHOW) begin
      if (presc != PRESC_LAST) begin
        presc <= presc + 1'b1;
      end else begin
        presc <= '0;
        if (digit != 2'd3) begin
          digit          <= digit_inc;
          anodo          <= anode_for(digit_inc, frame_cnt[3]);
          saida1Contador <= digit_inc[1];
          saida2Contador <= digit_inc[0];
        end else if (frame_cnt != 16'd0) begin
          // Frame end with frames remaining: start the next frame at digit 0.
          digit          <= 2'd0;
          frame_cnt      <= frame_dec;
          anodo          <= anode_for(2'd0, frame_dec[3]);
          saida1Contador <= 1'b0;
          saida2Contador <= 1'b0;
        end else begin
          // Last frame done: blank the display and park every counter at 0.
          state          <= IDLE;
          digit          <= 2'd0;
          anodo          <= 4'b1111;
          saida1Contador <= 1'b0;
          saida2Contador <= 1'b0;
          ativo          <= 1'b0;
        end
      end
    end
    // IDLE without a request: every register holds its value. The counters
    // are already 0 on every path into IDLE.
  end

endmodule

// File: tb/tb_contador_varredura_erro.sv
// -----------------------------------------------------------------------------
// tb_contador_varredura_erro
//
// Directed bench for contador_varredura_erro. Outputs are checked on the
// falling edge, and inputs are changed there as well. The parameters are
// chosen by the build: DIV=4, HOLD_FRAMES=2 by default, and DIV=1,
// HOLD_FRAMES=16 when ERDI_PISCA_EN is defined.
// -----------------------------------------------------------------------------
module tb_contador_varredura_erro;

`ifdef ERDI_PISCA_EN
  localparam int DIV   = 1;
  localparam int HOLD  = 16;
  localparam bit BLINK = 1'b1;
`else
  localparam int DIV   = 4;
  localparam int HOLD  = 2;
  localparam bit BLINK = 1'b0;
`endif
  localparam int MSG = 4 * DIV * HOLD;

  logic       clock;
  logic       reset_n;
  logic       erro_valor;
  logic       saida1Contador;
  logic       saida2Contador;
  logic [3:0] anodo;
  logic       ativo;

  int total;
  int bad;

  contador_varredura_erro #(
    .DIV        (DIV),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .erro_valor    (erro_valor),
    .saida1Contador(saida1Contador),
    .saida2Contador(saida2Contador),
    .anodo         (anodo),
    .ativo         (ativo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_anodo"}, 32'(anodo), 32'hf);
    check({tag, "_sel"},   32'({saida1Contador, saida2Contador}), 32'h0);
    check({tag, "_ativo"}, 32'(ativo), 32'h1 ^ 32'h1);
  endtask

  // Expected outputs for cycle i of an unretriggered message, where cycle 0
  // is the cycle right after the request edge.
  task automatic show_cycle(input int i);
    logic [1:0]  d;
    logic [15:0] fc;
    logic [3:0]  ea;
    d  = 2'((i / DIV) % 4);
    fc = 16'(HOLD - 1 - i / (4 * DIV));
    ea = (BLINK && fc[3]) ? 4'b1111 : ~(4'b0001 << d);
    check($sformatf("anodo_c%0d", i), 32'(anodo), 32'(ea));
    check($sformatf("sel_c%0d", i),   32'({saida1Contador, saida2Contador}), 32'(d));
    check($sformatf("ativo_c%0d", i), 32'(ativo), 32'h1);
  endtask

  task automatic show_run(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      show_cycle(i);
      @(negedge clock);
    end
  endtask

  // One-cycle request, issued from a falling edge. The task returns at
  // cycle 0 of the message.
  task automatic pulse();
    erro_valor = 1'b1;
    @(negedge clock);
    erro_valor = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset_n    = 1'b1;
    erro_valor = 1'b0;

    // Asynchronous reset in the low phase, before any rising edge.
    #2 reset_n = 1'b0;
    #1 idle_check("rst_async");
    @(negedge clock);
    for (int k = 0; k < 10; k++) begin
      idle_check("rst_hold");
      @(negedge clock);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      idle_check("idle_no_req");
    end

    // Single pulse: full message, then back to idle.
    pulse();
    show_run(0, MSG - 1);
    idle_check("end_single");
    @(negedge clock);
    idle_check("end_single_2");

    // Retrigger at cycle 20 restarts the scan at digit 0 for a full message.
    pulse();
    show_run(0, 19);
    pulse();
    show_run(0, MSG - 1);
    idle_check("end_retrig");

    // Request on the final 3->0 wrap: no idle cycle, new message at digit 0.
    @(negedge clock);
    pulse();
    show_run(0, MSG - 2);
    show_cycle(MSG - 1);
    pulse();
    show_run(0, MSG - 1);
    idle_check("end_wrap");

    // Reset at cycle 10: idle values immediately, and no display afterwards.
    @(negedge clock);
    pulse();
    show_run(0, 9);
    #2 reset_n = 1'b0;
    #1 idle_check("rst_mid");
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      idle_check("after_rst");
    end

    // A fresh request still works after the reset.
    pulse();
    show_run(0, MSG - 1);
    idle_check("end_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/contador_varredura_erro.md
# contador_varredura_erro

Scan controller directly upstream of the money-validation error decoder (interfaceERDI). It latches an error request, then generates the 2-bit digit-select pair `saida1Contador`/`saida2Contador` that drives the decoder. It also drives the four active-low digit anodes of the multiplexed 7-segment display. The message is held on the display for a fixed number of scan frames, then the display is blanked.

## Interface
- `DIV`, 50000: clock cycles each digit stays lit (prescaler period); legal range ≥1.
- `HOLD_FRAMES`, 250: complete 4-digit scan frames the message is shown per request; legal range ≥1, ≤65535.
- `clock` input 1: single system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `erro_valor` input 1: error request from validation logic, sampled each rising edge; a pulse or a level.
- `saida1Contador` output 1: digit-select MSB to decoder.
- `saida2Contador` output 1: digit-select LSB to decoder.
- `anodo` output 4: active-low digit enables; bit n low ⇔ digit n lit.
- `ativo` output 1: high while the message is being displayed.

## Operation
- Two states: IDLE, SHOW. All outputs registered.
- IDLE:
  - `anodo`=4'b1111, select=00, `ativo`=0.
  - Prescaler and frame counter are held at 0.
- IDLE→SHOW: `erro_valor`=1 at a clock edge.
  - Load frame counter with HOLD_FRAMES-1.
  - Prescaler=0, digit=0.
- SHOW:
  - `ativo`=1.
  - `anodo`=~(4'b0001<<digit).
  - {saida1Contador,saida2Contador}=digit (saida1Contador = digit[1]).
- Prescaler:
  - Counts 0..DIV-1.
  - At DIV-1 it wraps to 0 and digit increments mod 4.
- Frame end: the wrap from digit 3 to digit 0.
  - Frame counter ≠0: decrement the counter and stay in SHOW.
  - Frame counter =0: go to IDLE.
- Retrigger: `erro_valor`=1 in any SHOW cycle reloads frame counter, prescaler and digit exactly as on entry.
  - The scan restarts at digit 0.
  - Retrigger has priority over a simultaneous frame end, so the block stays in SHOW.
- `erro_valor` held high: the block stays at digit 0, retriggered every cycle; this is the documented behaviour.
- Width rules:
  - Prescaler width is $clog2(DIV), minimum 1.
  - Frame counter is 16 bits.
  - The digit counter is 2 bits and wraps naturally.
- Reset mid-SHOW: outputs go to IDLE values immediately, without waiting for a clock.

## Timing
- Reset values:
  - `anodo`=4'b1111, `saida1Contador`=0, `saida2Contador`=0, `ativo`=0.
  - State IDLE; all counters 0.
- Request latency: outputs change on the first rising edge at which `erro_valor`=1 is sampled.
  - That same edge gives `anodo`=4'b1110, select=00, `ativo`=1.
- Each digit is lit for exactly DIV cycles.
- An unretriggered message lasts exactly 4·DIV·HOLD_FRAMES cycles of `ativo`=1.
- Select and anode change on the same edge, so no cycle has a mismatched select and anode.
- DIV=1: the digit advances every cycle.

## Configuration
- `ERDI_PISCA_EN`, when defined: the message blinks.
  - `anodo` is forced to 4'b1111 during frames where frame counter bit 3 is 1.
  - This gives 8 frames on and 8 frames off, counted down from the load value.
  - Select outputs and `ativo` are unaffected.
  - Total duration is unchanged.
- Not defined: the message is lit continuously in every frame of SHOW.

## Test plan
Default bench parameters: DIV=4, HOLD_FRAMES=2.
- Reset: assert `reset_n`=0 mid-clock → outputs reach the reset values without a clock edge; hold them through 10 idle cycles.
- Single 1-cycle pulse on `erro_valor` → `ativo`=1 for exactly 32 cycles.
  - `anodo` sequence is 1110,1101,1011,0111, each for 4 cycles, repeated twice.
  - Select sequence is 00,01,10,11.
  - Then `anodo`=1111 and `ativo`=0.
- Retrigger at cycle 20 of SHOW → digit returns to 0 on that edge, and `ativo` stays 1 for 32 more cycles.
- Pulse coinciding with the final 3→0 wrap (cycle 31) → no IDLE cycle; a new 32-cycle message starts at digit 0.
- Reset asserted at cycle 10 of SHOW → immediate IDLE values; after release, no display until a new request.
- With `ERDI_PISCA_EN` defined, DIV=1, HOLD_FRAMES=16:
  - `anodo`=1111 for the first 32 cycles, then it scans for 32 cycles.
  - `ativo`=1 for all 64 cycles.
